// File: rtl/wb_arbiter.sv
// Register-file write-port arbiter: fixed-priority ALU writeback merged with a
// FIFO-buffered LSU writeback, plus read-after-write hazard reporting for decode.
module wb_arbiter #(
   parameter int DEPTH = 4,
   parameter int AW    = 5,
   parameter int DW    = 32
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     alu_we,
   input  logic [AW-1:0]            alu_rd,
   input  logic [DW-1:0]            alu_wd,
   input  logic                     lsu_valid,
   output logic                     lsu_ready,
   input  logic [AW-1:0]            lsu_rd,
   input  logic [DW-1:0]            lsu_wd,
   input  logic [AW-1:0]            rs1,
   input  logic [AW-1:0]            rs2,
   output logic                     hazard1,
   output logic                     hazard2,
   output logic                     we3,
   output logic [AW-1:0]            a3,
   output logic [DW-1:0]            wd3,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   logic [DEPTH-1:0] ent_vld;
   logic [AW-1:0]    ent_rd [DEPTH];
   logic [DW-1:0]    ent_wd [DEPTH];
   logic [PW-1:0]    rptr;
   logic [PW-1:0]    wptr;

   logic alu_grant;
   logic push;
   logic pop;
   logic not_empty;
   logic pend1;
   logic pend2;

   // x0 never names a real destination, so it can neither match nor be matched.
   function automatic logic addr_hit(input logic [AW-1:0] a, input logic [AW-1:0] b);
      return (a != '0) && (a == b);
   endfunction

   assign not_empty = (count != '0);
   assign lsu_ready = rst_n & (count != FULL);
   assign alu_grant = alu_we & (alu_rd != '0);
   assign push      = lsu_valid & lsu_ready & (lsu_rd != '0);
   assign pop       = ~alu_grant & not_empty;

   // FIFO control: pointers, occupancy and per-entry valid (squash) bits.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rptr    <= '0;
         wptr    <= '0;
         count   <= '0;
         ent_vld <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (alu_grant && ent_vld[i] && addr_hit(alu_rd, ent_rd[i]))
               ent_vld[i] <= 1'b0;
         end
         if (pop) begin
            ent_vld[rptr] <= 1'b0;
            rptr          <= rptr + PW'(1);
         end
         if (push) begin
            ent_vld[wptr] <= ~(alu_grant && addr_hit(alu_rd, lsu_rd));
            wptr          <= wptr + PW'(1);
         end
         count <= count + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         ent_rd[wptr] <= lsu_rd;
         ent_wd[wptr] <= lsu_wd;
      end
   end

   // Write-port register stage: ALU first, else FIFO head, else idle.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         we3 <= 1'b0;
         a3  <= '0;
         wd3 <= '0;
      end else if (alu_grant) begin
         we3 <= 1'b1;
         a3  <= alu_rd;
         wd3 <= alu_wd;
      end else if (not_empty) begin
         we3 <= ent_vld[rptr];
         a3  <= ent_rd[rptr];
         wd3 <= ent_wd[rptr];
      end else begin
         we3 <= 1'b0;
      end
   end

   // Pending writes: the registered port commits next edge, so it counts too.
   always_comb begin
      pend1 = 1'b0;
      pend2 = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         pend1 = pend1 | (ent_vld[i] & addr_hit(rs1, ent_rd[i]));
         pend2 = pend2 | (ent_vld[i] & addr_hit(rs2, ent_rd[i]));
      end
      hazard1 = pend1 | (we3 & addr_hit(rs1, a3));
      hazard2 = pend2 | (we3 & addr_hit(rs2, a3));
   end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: expected commits are queued at stimulus time
// and matched by a monitor against every we3 pulse.
module tb_wb_arbiter;

   localparam int DEPTH = 4;
   localparam int AW    = 5;
   localparam int DW    = 32;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          alu_we;
   logic [AW-1:0] alu_rd;
   logic [DW-1:0] alu_wd;
   logic          lsu_valid;
   logic          lsu_ready;
   logic [AW-1:0] lsu_rd;
   logic [DW-1:0] lsu_wd;
   logic [AW-1:0] rs1;
   logic [AW-1:0] rs2;
   logic          hazard1;
   logic          hazard2;
   logic          we3;
   logic [AW-1:0] a3;
   logic [DW-1:0] wd3;
   logic [CW-1:0] count;

   int tests = 0;
   int fails = 0;

   logic [AW+DW-1:0] exp_q[$];
   logic [AW+DW-1:0] pend_q[$];

   always #5 clk = ~clk;

   wb_arbiter #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
      .clk(clk), .rst_n(rst_n),
      .alu_we(alu_we), .alu_rd(alu_rd), .alu_wd(alu_wd),
      .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_wd(lsu_wd),
      .rs1(rs1), .rs2(rs2), .hazard1(hazard1), .hazard2(hazard2),
      .we3(we3), .a3(a3), .wd3(wd3), .count(count)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      tests++;
      assert (obs === expv)
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Every commit must be the next expected one; any extra commit is an error.
   always @(negedge clk) begin
      if (we3 === 1'b1) begin
         if (exp_q.size() == 0) begin
            chk("commit_unexpected", 64'(we3), 64'd0);
         end else begin
            logic [AW+DW-1:0] e;
            e = exp_q.pop_front();
            chk("commit", 64'({a3, wd3}), 64'(e));
         end
      end
   end

   initial begin
      int lsu_i;
      int budget;

      rst_n = 1'b0; alu_we = 1'b0; alu_rd = '0; alu_wd = '0;
      lsu_valid = 1'b1; lsu_rd = 5'd3; lsu_wd = 32'h5555; rs1 = '0; rs2 = '0;

      // reset with lsu_valid asserted
      tick(); tick();
      chk("rst_we3", 64'(we3), 64'd0);
      chk("rst_a3", 64'(a3), 64'd0);
      chk("rst_wd3", 64'(wd3), 64'd0);
      chk("rst_count", 64'(count), 64'd0);
      chk("rst_ready", 64'(lsu_ready), 64'd0);
      rst_n = 1'b1; lsu_valid = 1'b0;
      #1 chk("rel_ready", 64'(lsu_ready), 64'd1);
      tick();
      chk("rel_count", 64'(count), 64'd0);

      // ALU only
      alu_we = 1'b1; alu_rd = 5'd5; alu_wd = 32'hDEADBEEF; rs1 = 5'd5;
      exp_q.push_back({5'd5, 32'hDEADBEEF});
      #1 chk("alu_no_incoming_hz", 64'(hazard1), 64'd0);
      tick();
      alu_we = 1'b0;
      chk("alu_we3", 64'(we3), 64'd1);
      chk("alu_a3", 64'(a3), 64'd5);
      chk("alu_wd3", 64'(wd3), 64'hDEADBEEF);
      chk("alu_hz1_c1", 64'(hazard1), 64'd1);
      tick();
      chk("alu_hz1_c2", 64'(hazard1), 64'd0);
      chk("alu_we3_c2", 64'(we3), 64'd0);

      // LSU latency
      lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_wd = 32'h1234; rs2 = 5'd7;
      exp_q.push_back({5'd7, 32'h1234});
      tick();
      lsu_valid = 1'b0;
      chk("lsu_count1", 64'(count), 64'd1);
      chk("lsu_hz2", 64'(hazard2), 64'd1);
      chk("lsu_we3_n1", 64'(we3), 64'd0);
      tick();
      chk("lsu_we3_n2", 64'(we3), 64'd1);
      chk("lsu_a3", 64'(a3), 64'd7);
      chk("lsu_wd3", 64'(wd3), 64'h1234);
      chk("lsu_count0", 64'(count), 64'd0);
      tick();
      chk("lsu_hz2_clear", 64'(hazard2), 64'd0);

      // backpressure: ALU busy while LSU issues rd=1..6
      lsu_i = 1;
      for (int c = 0; c < 6; c++) begin
         logic acc;
         alu_we = 1'b1; alu_rd = 5'd20; alu_wd = 32'hA000 + 32'(c);
         exp_q.push_back({5'd20, 32'hA000 + 32'(c)});
         lsu_valid = (lsu_i <= 6); lsu_rd = 5'(lsu_i); lsu_wd = 32'h100 + 32'(lsu_i);
         #1 acc = lsu_valid & lsu_ready;
         if (acc) pend_q.push_back({5'(lsu_i), 32'h100 + 32'(lsu_i)});
         tick();
         if (acc) lsu_i++;
      end
      chk("bp_count_full", 64'(count), 64'd4);
      chk("bp_ready_low", 64'(lsu_ready), 64'd0);
      alu_we = 1'b0;
      while (pend_q.size() > 0) exp_q.push_back(pend_q.pop_front());
      budget = 0;
      while (!(exp_q.size() == 0 && lsu_i > 6 && count == 0) && budget < 30) begin
         logic acc;
         lsu_valid = (lsu_i <= 6); lsu_rd = 5'(lsu_i); lsu_wd = 32'h100 + 32'(lsu_i);
         #1 acc = lsu_valid & lsu_ready;
         if (acc) exp_q.push_back({5'(lsu_i), 32'h100 + 32'(lsu_i)});
         tick();
         if (acc) lsu_i++;
         budget++;
      end
      lsu_valid = 1'b0;
      chk("bp_drain_done", 64'(budget < 30), 64'd1);
      chk("bp_count_empty", 64'(count), 64'd0);

      // squash of a queued entry
      lsu_valid = 1'b1; lsu_rd = 5'd9; lsu_wd = 32'hAAAA; rs1 = 5'd9;
      tick();
      lsu_valid = 1'b0;
      chk("sq_hz_pending", 64'(hazard1), 64'd1);
      alu_we = 1'b1; alu_rd = 5'd9; alu_wd = 32'hBBBB;
      exp_q.push_back({5'd9, 32'hBBBB});
      tick();
      alu_we = 1'b0;
      chk("sq_wd3", 64'(wd3), 64'hBBBB);
      chk("sq_count_kept", 64'(count), 64'd1);
      tick();
      chk("sq_bubble", 64'(we3), 64'd0);
      chk("sq_count0", 64'(count), 64'd0);
      chk("sq_hz_clear", 64'(hazard1), 64'd0);

      // squash of an entry pushed in the same cycle
      alu_we = 1'b1; alu_rd = 5'd11; alu_wd = 32'hC0DE;
      lsu_valid = 1'b1; lsu_rd = 5'd11; lsu_wd = 32'hBAD0;
      exp_q.push_back({5'd11, 32'hC0DE});
      tick();
      alu_we = 1'b0; lsu_valid = 1'b0;
      chk("sq2_count", 64'(count), 64'd1);
      tick();
      chk("sq2_bubble", 64'(we3), 64'd0);

      // simultaneous push and pop
      lsu_valid = 1'b1; lsu_rd = 5'd12; lsu_wd = 32'h12;
      exp_q.push_back({5'd12, 32'h12});
      tick();
      lsu_rd = 5'd13; lsu_wd = 32'h13;
      exp_q.push_back({5'd13, 32'h13});
      tick();
      lsu_valid = 1'b0;
      chk("pp_count", 64'(count), 64'd1);
      chk("pp_a3", 64'(a3), 64'd12);
      tick();
      chk("pp_a3_next", 64'(a3), 64'd13);
      chk("pp_count0", 64'(count), 64'd0);

      // x0 handling
      lsu_valid = 1'b1; lsu_rd = 5'd0; lsu_wd = 32'hFFFF;
      #1 chk("x0_ready", 64'(lsu_ready), 64'd1);
      tick();
      lsu_valid = 1'b0;
      chk("x0_lsu_count", 64'(count), 64'd0);
      alu_we = 1'b1; alu_rd = 5'd0; alu_wd = 32'hEEEE; rs1 = 5'd0;
      tick();
      alu_we = 1'b0;
      chk("x0_alu_we3", 64'(we3), 64'd0);
      chk("x0_hz1", 64'(hazard1), 64'd0);

      // reset mid-operation discards queued writes
      alu_we = 1'b1; alu_rd = 5'd21; alu_wd = 32'h2121;
      lsu_valid = 1'b1; lsu_rd = 5'd14; lsu_wd = 32'h1414;
      exp_q.push_back({5'd21, 32'h2121});
      tick();
      alu_we = 1'b0; lsu_valid = 1'b0; rst_n = 1'b0;
      chk("mr_count_before", 64'(count), 64'd1);
      tick();
      chk("mr_count", 64'(count), 64'd0);
      chk("mr_we3", 64'(we3), 64'd0);
      chk("mr_ready", 64'(lsu_ready), 64'd0);
      rst_n = 1'b1;
      tick(); tick();
      chk("mr_after_we3", 64'(we3), 64'd0);
      chk("mr_after_count", 64'(count), 64'd0);
      chk("exp_queue_empty", 64'(exp_q.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
